// File: rtl/store_trace_fifo.sv
// Store trace FIFO: captures every core data-memory store into a first-word-fall-through
// FIFO drained by a valid/ready stream. Optional signature checker: STORE_TRACE_SIGNATURE_CHECK_EN.
module store_trace_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            full;
  logic            pop;
  logic            push;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign push      = memwrite && (!full || pop);

  assign out_addr  = mem[head].addr;
  assign out_data  = mem[head].data;

  // Pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (memwrite && !push) overflow <= 1'b1;
    end
  end

  // Storage array; no reset needed since out_valid qualifies the head.
  always_ff @(posedge clk) begin
    if (reset && push) mem[tail] <= '{addr: dataadr, data: writedata};
  end

`ifdef STORE_TRACE_SIGNATURE_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  // Pass signature wins over the stray-address fail; every store is judged, dropped or not.
  always_comb begin
    state_next = state;
    if (state == ST_RUN && memwrite) begin
      if (dataadr == PASS_ADDR && writedata == PASS_DATA) state_next = ST_PASS;
      else if (dataadr != ALLOW_ADDR)                     state_next = ST_FAIL;
    end
  end

  assign done = (state != ST_RUN);
  assign pass = (state == ST_PASS);
`else
  logic unused_sig_cfg;
  assign unused_sig_cfg = ^{PASS_ADDR, PASS_DATA, ALLOW_ADDR};
  assign done = 1'b0;
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_store_trace_fifo.sv
// Testbench for store_trace_fifo: table-driven reset/capture vectors plus hand-written
// overflow, wrap-around and signature sequences.
module tb_store_trace_fifo;

`ifdef STORE_TRACE_SIGNATURE_CHECK_EN
  localparam bit SIG = 1'b1;
`else
  localparam bit SIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        overflow;
  logic        done;
  logic        pass;

  int checks = 0;
  int errors = 0;

  store_trace_fifo #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .count(count),
    .overflow(overflow), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    int          e_cnt;
    logic        e_val;
    logic        e_ovf;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic mw, input logic [31:0] adr,
                       input logic [31:0] wd, input logic rdy);
    reset = rst; memwrite = mw; dataadr = adr; writedata = wd; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] q[$];
    int popped;
    int guard;

    // Reset held with a store present, then ordered capture and drain.
    vecs[0]  = '{1'b0, 1'b1, 32'd80, 32'd9, 1'b0, 0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'd80, 32'd9, 1'b0, 0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[2]  = '{1'b1, 1'b1, 32'd80, 32'd1, 1'b0, 1, 1'b1, 1'b0, 32'd80, 32'd1};
    vecs[3]  = '{1'b1, 1'b1, 32'd80, 32'd2, 1'b0, 2, 1'b1, 1'b0, 32'd80, 32'd1};
    vecs[4]  = '{1'b1, 1'b1, 32'd80, 32'd3, 1'b0, 3, 1'b1, 1'b0, 32'd80, 32'd1};
    vecs[5]  = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 2, 1'b1, 1'b0, 32'd80, 32'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 1, 1'b1, 1'b0, 32'd80, 32'd3};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[9]  = '{1'b1, 1'b1, 32'd80, 32'd4, 1'b1, 1, 1'b1, 1'b0, 32'd80, 32'd4};
    vecs[10] = '{1'b1, 1'b1, 32'd80, 32'd5, 1'b1, 1, 1'b1, 1'b0, 32'd80, 32'd5};
    vecs[11] = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 0, 1'b0, 1'b0, 32'd0,  32'd0};

    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].rdy);
      step();
      check($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_val));
      check($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
      check($sformatf("v%0d done", i), 64'(done), 64'd0);
      check($sformatf("v%0d pass", i), 64'(pass), 64'd0);
      if (vecs[i].e_val) begin
        check($sformatf("v%0d out_addr", i), 64'(out_addr), 64'(vecs[i].e_addr));
        check($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].e_data));
      end
    end

    // Overflow: 9 stores into 8 slots, ninth is dropped.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 32'd80, 32'(100 + i), 1'b0);
      step();
    end
    check("ovf count full", 64'(count), 64'd8);
    check("ovf flag set", 64'(overflow), 64'd1);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf drain %0d", i), 64'(out_data), 64'(100 + i));
      step();
    end
    check("ovf drained count", 64'(count), 64'd0);
    check("ovf ninth absent", 64'(out_valid), 64'd0);
    check("ovf sticky", 64'(overflow), 64'd1);

    // Full with simultaneous pop: ninth store accepted.
    do_reset();
    check("reset clears ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 32'd80, 32'(200 + i), (i == 8) ? 1'b1 : 1'b0);
      step();
    end
    check("full pushpop count", 64'(count), 64'd8);
    check("full pushpop no ovf", 64'(overflow), 64'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full pushpop drain %0d", i), 64'(out_data), 64'(201 + i));
      step();
    end
    check("full pushpop empty", 64'(count), 64'd0);

    // Wrap-around with a queue scoreboard: 20 stores over 30 cycles, ready toggling.
    do_reset();
    popped = 0;
    q.delete();
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, (c % 3) != 2, 32'h1000 + 32'(c), 32'(popped), (c % 2) == 1);
      writedata = 32'(c - c / 3);
      if (out_valid !== (q.size() != 0)) check($sformatf("wrap valid c%0d", c), 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0 && out_ready) begin
        check($sformatf("wrap data %0d", popped), 64'(out_data), 64'(q[0]));
        void'(q.pop_front());
        popped++;
      end
      if (memwrite) q.push_back(writedata);
      step();
    end
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    guard = 0;
    while (q.size() != 0 && guard < 16) begin
      check($sformatf("wrap data %0d", popped), 64'(out_data), 64'(q[0]));
      void'(q.pop_front());
      popped++;
      guard++;
      step();
    end
    check("wrap popped total", 64'(popped), 64'd20);
    check("wrap count empty", 64'(count), 64'd0);
    check("wrap no ovf", 64'(overflow), 64'd0);

    // Signature pass, then a later stray store must not undo it.
    do_reset();
    drive(1'b1, 1'b1, 32'd80, 32'd5, 1'b1);
    step();
    check("sig pass first done", 64'(done), 64'd0);
    drive(1'b1, 1'b1, 32'd84, 32'd7, 1'b1);
    step();
    check("sig pass done", 64'(done), 64'(SIG));
    check("sig pass pass", 64'(pass), 64'(SIG));
    drive(1'b1, 1'b1, 32'd96, 32'd1, 1'b1);
    step();
    check("sig pass sticky", 64'(pass), 64'(SIG));
    check("sig pass capture", 64'(out_data), 64'd1);

    // Signature fail: right address, wrong data.
    do_reset();
    drive(1'b1, 1'b1, 32'd84, 32'd6, 1'b0);
    step();
    check("sig fail84 done", 64'(done), 64'(SIG));
    check("sig fail84 pass", 64'(pass), 64'd0);

    // Signature fail: stray address, then a pass store cannot recover.
    do_reset();
    check("reset clears done", 64'(done), 64'd0);
    drive(1'b1, 1'b1, 32'd88, 32'd7, 1'b0);
    step();
    check("sig fail88 done", 64'(done), 64'(SIG));
    check("sig fail88 pass", 64'(pass), 64'd0);
    drive(1'b1, 1'b1, 32'd84, 32'd7, 1'b0);
    step();
    check("sig fail terminal done", 64'(done), 64'(SIG));
    check("sig fail terminal pass", 64'(pass), 64'd0);
    check("sig fail capture count", 64'(count), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_trace_fifo.md
# store_trace_fifo

Downstream observer of the single-cycle core's data-memory write port (`memwrite`, `dataadr`, `writedata`), instantiated alongside `top`. Every store the core issues is captured into a first-word-fall-through FIFO and drained through a valid/ready stream, for trace export or a debug UART. An optional signature checker reproduces the bench's pass/fail rule in hardware: a store of `PASS_DATA` to `PASS_ADDR` means pass, and a store to any address other than `ALLOW_ADDR` or `PASS_ADDR` means fail.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `PASS_ADDR`, default 84: signature store address.
- `PASS_DATA`, default 7: signature store data.
- `ALLOW_ADDR`, default 80: the only other address a store may target without failing.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `memwrite`, input, 1: core store strobe, sampled each rising edge.
- `dataadr`, input, 32: store address.
- `writedata`, input, 32: store data.
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_addr`, output, 32: head entry address.
- `out_data`, output, 32: head entry data.
- `count`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky; set when a store was dropped.
- `done`, output, 1: the checker has reached a terminal state.
- `pass`, output, 1: the terminal state is PASS.

## Operation
- Push: `memwrite==1` at an edge writes {`dataadr`, `writedata`} at the tail, unless the push is rejected.
- Pop: `out_valid && out_ready` at an edge advances the head.
- Simultaneous push and pop:
  - Always allowed, including when full; `count` is unchanged.
  - When empty, the pushed entry appears next cycle; no same-cycle bypass.
- Full, push, no pop: the entry is dropped, `overflow` is set to 1, and `count` stays at DEPTH. `overflow` clears only on reset.
- Empty pop: impossible, because `out_valid==0`; `out_ready` is ignored.
- Pointers: $clog2(DEPTH) bits wide, wrap modulo DEPTH. Occupancy is tracked by `count`, not by pointer compare.
- Head outputs: `out_addr`/`out_data` come combinationally from the head register. They are don't-care while `out_valid==0`.
- Checker FSM, states RUN, PASS, FAIL:
  - RUN, `memwrite` with `dataadr==PASS_ADDR && writedata==PASS_DATA` -> PASS. This condition has priority over the fail condition.
  - RUN, `memwrite` with `dataadr!=ALLOW_ADDR` and not the pass condition -> FAIL. This includes a store to `PASS_ADDR` with wrong data.
  - RUN, store to `ALLOW_ADDR`, or no store -> stays in RUN.
  - PASS and FAIL are terminal until reset.
  - The checker evaluates every store, even one the FIFO drops.
- Decodes: `done = (state!=RUN)`, `pass = (state==PASS)`.
- Capture continues after `done`.
- Comparisons are full 32-bit equality. X/Z on inputs while `memwrite==0` has no effect.

## Timing
- Reset values:
  - `count=0`, `out_valid=0`, `overflow=0`, `done=0`, `pass=0`.
  - State = RUN; head and tail pointers = 0.
  - `out_addr`/`out_data` are don't-care.
- Reset mid-operation: all FIFO contents are discarded. Reset overrides a push or pop in the same edge.
- Latency:
  - A store sampled at edge N is visible as `out_valid`/`out_addr`/`out_data` after edge N when the FIFO was empty.
  - `done`/`pass` are set after the same edge N as the deciding store.
- Throughput: one push and one pop per cycle.
- `count`, `overflow`, `done`, `pass` are registered outputs; `out_valid` is `count!=0`.

## Configuration
- `STORE_TRACE_SIGNATURE_CHECK_EN` defined: the checker FSM and comparators are compiled in, and the parameters `PASS_ADDR`, `PASS_DATA`, `ALLOW_ADDR` take effect.
- `STORE_TRACE_SIGNATURE_CHECK_EN` undefined: no FSM; `done` and `pass` are tied to 0. The parameters remain declared but are unused. FIFO behaviour is identical in both builds.

## Test plan
- Reset:
  - Hold `reset=0` for 2 edges with `memwrite=1`, `dataadr=80` -> `count=0`, `out_valid=0`, `overflow=0`, `done=0`.
  - Release reset -> the first store is captured one edge later.
- Ordered capture: stores (80,1), (80,2), (80,3) with `out_ready=0`, then `out_ready=1` -> `count` reaches 3; pops return addr 80 with data 1, 2, 3 in order; `count` ends at 0.
- Overflow (DEPTH=8): 9 consecutive stores with `out_ready=0` -> `count=8`, `overflow=1`, 9th store absent from the drained data. Repeat with `out_ready=1` on the 9th edge -> no drop, `count` stays 8.
- Wrap-around: 20 stores (data 0..19) with `out_ready` toggling every cycle -> all 20 values drained in order, `overflow=0`.
- Signature pass (macro on): (80,5) then (84,7) -> `done=0` after the first; `done=1`, `pass=1` after the second; a later store to 96 leaves `pass=1`.
- Signature fail (macro on): (84,6) -> `done=1`, `pass=0`. Separately, (88,7) -> `done=1`, `pass=0`. With the macro off, both sequences leave `done=0`, `pass=0`.
